pipe_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Merges the hazard-detector stall request,
//  EXE-stage branch-taken and MEM-stage SRAM wait into per-register freeze/flush/bubble controls.

---
 rtl/pipe_stall_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It merges the
//   hazard-detector stall request, the EXE-stage branch-taken signal and the
//   MEM-stage SRAM wait into per-register freeze/flush/bubble controls for the
//   PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.
//
//   Priority: memory wait > branch flush > hazard stall.
//   Outputs are combinational from the registered state and the current
//   inputs, so a stall takes effect in the same cycle it is requested.
//
// Parameters
//   FLUSH_CYCLES  IF/ID flush cycles per taken branch (1..15)
//   MEM_TIMEOUT   wait cycles before an SRAM access is abandoned (2..255)
//
// Ports
//   clk           pipeline clock, rising edge
//   rst           synchronous active-high reset
//   hazard        stall request from the hazard detector
//   branch_taken  EXE-stage branch taken this cycle
//   mem_req       MEM stage holds a load or store
//   sram_ready    SRAM access completes this cycle
//   freeze_pc     hold the PC
//   freeze_ifid   hold IF/ID
//   flush_ifid    clear IF/ID to NOP
//   bubble_idexe  load NOP into ID/EXE
//   freeze_back   hold ID/EXE, EXE/MEM and MEM/WB
//   mem_timeout   sticky flag: an SRAM wait exceeded MEM_TIMEOUT
//
// Optional feature (macro STALL_STATS_EN)
//   Adds saturating 16-bit counters stat_stall (hazard-stall cycles),
//   stat_flush (taken branches) and stat_memw (freeze_back cycles), all
//   cleared by rst. Without the macro these ports do not exist.

module pipe_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        sram_ready,
  output logic        freeze_pc,
  output logic        freeze_ifid,
  output logic        flush_ifid,
  output logic        bubble_idexe,
  output logic        freeze_back,
  output logic        mem_timeout
`ifdef STALL_STATS_EN
  ,
  output logic [15:0] stat_stall,
  output logic [15:0] stat_flush,
  output logic [15:0] stat_memw
`endif
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       resume_flush, resume_flush_nxt;
  logic       mem_timeout_q, timeout_set;
  logic       mem_stall;
  logic       hazard_evt, branch_evt;
  logic       f_pc, f_ifid, f_flush, f_bubble, f_back;

  assign mem_stall = mem_req & ~sram_ready;

  // Next-state and raw control decode. Branch and hazard are only looked at
  // in RUN; in MEM_WAIT the EXE stage is frozen so both are re-evaluated once
  // the wait releases.
  always_comb begin
    state_nxt        = state;
    flush_cnt_nxt    = flush_cnt;
    wait_cnt_nxt     = wait_cnt;
    resume_flush_nxt = resume_flush;
    timeout_set      = 1'b0;
    hazard_evt       = 1'b0;
    branch_evt       = 1'b0;
    f_pc             = 1'b0;
    f_ifid           = 1'b0;
    f_flush          = 1'b0;
    f_bubble         = 1'b0;
    f_back           = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          f_pc         = 1'b1;
          f_ifid       = 1'b1;
          f_back       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else if (branch_taken) begin
          f_flush    = 1'b1;
          f_bubble   = 1'b1;
          branch_evt = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_INIT;
          end
        end else if (hazard) begin
          f_pc       = 1'b1;
          f_ifid     = 1'b1;
          f_bubble   = 1'b1;
          hazard_evt = 1'b1;
        end
      end
      FLUSH: begin
        // The remaining flush count is held across a memory wait and the
        // flush resumes where it left off.
        if (mem_stall) begin
          f_pc             = 1'b1;
          f_ifid           = 1'b1;
          f_back           = 1'b1;
          resume_flush_nxt = 1'b1;
          state_nxt        = MEM_WAIT;
          wait_cnt_nxt     = 8'd1;
        end else begin
          f_flush = 1'b1;
          if (flush_cnt <= 4'd1) begin
            state_nxt     = RUN;
            flush_cnt_nxt = 4'd0;
          end else begin
            flush_cnt_nxt = flush_cnt - 4'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_req && sram_ready) begin
          state_nxt        = resume_flush ? FLUSH : RUN;
          resume_flush_nxt = 1'b0;
          wait_cnt_nxt     = 8'd0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          // Abandon the access: release the pipeline and drop any pending flush.
          timeout_set      = 1'b1;
          state_nxt        = RUN;
          resume_flush_nxt = 1'b0;
          flush_cnt_nxt    = 4'd0;
          wait_cnt_nxt     = 8'd0;
        end else begin
          f_pc         = 1'b1;
          f_ifid       = 1'b1;
          f_back       = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // All outputs are forced low while reset is held, regardless of state.
  always_comb begin
    freeze_pc    = f_pc & ~rst;
    freeze_ifid  = f_ifid & ~rst;
    flush_ifid   = f_flush & ~rst;
    bubble_idexe = f_bubble & ~rst;
    freeze_back  = f_back & ~rst;
    mem_timeout  = mem_timeout_q & ~rst;
  end

  // State registers; mem_timeout_q is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      flush_cnt     <= 4'd0;
      wait_cnt      <= 8'd0;
      resume_flush  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      flush_cnt    <= flush_cnt_nxt;
      wait_cnt     <= wait_cnt_nxt;
      resume_flush <= resume_flush_nxt;
      if (timeout_set) begin
        mem_timeout_q <= 1'b1;
      end
    end
  end

`ifdef STALL_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall <= 16'd0;
      stat_flush <= 16'd0;
      stat_memw  <= 16'd0;
    end else begin
      if (hazard_evt && stat_stall != 16'hFFFF) begin
        stat_stall <= stat_stall + 16'd1;
      end
      if (branch_evt && stat_flush != 16'hFFFF) begin
        stat_flush <= stat_flush + 16'd1;
      end
      if (f_back && stat_memw != 16'hFFFF) begin
        stat_memw <= stat_memw + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=8).
// Directed per-cycle vectors push their expected output word into a queue;
// a monitor on the falling edge pops and compares against the DUT outputs.
// Output word bit order: {freeze_pc, freeze_ifid, flush_ifid, bubble_idexe,
// freeze_back, mem_timeout}.

module tb_pipe_stall_ctrl;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] HAZ  = 6'b110100;
  localparam logic [5:0] BR   = 6'b001100;
  localparam logic [5:0] FL   = 6'b001000;
  localparam logic [5:0] FRZ  = 6'b110010;
  localparam logic [5:0] TMO  = 6'b000001;

  typedef struct {
    string      name;
    logic [5:0] value;
  } exp_t;

  logic clk, rst, hazard, branch_taken, mem_req, sram_ready;
  logic freeze_pc, freeze_ifid, flush_ifid, bubble_idexe, freeze_back, mem_timeout;
`ifdef STALL_STATS_EN
  logic [15:0] stat_stall, stat_flush, stat_memw;
`endif

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  pipe_stall_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .sram_ready   (sram_ready),
    .freeze_pc    (freeze_pc),
    .freeze_ifid  (freeze_ifid),
    .flush_ifid   (flush_ifid),
    .bubble_idexe (bubble_idexe),
    .freeze_back  (freeze_back),
    .mem_timeout  (mem_timeout)
`ifdef STALL_STATS_EN
    ,
    .stat_stall   (stat_stall),
    .stat_flush   (stat_flush),
    .stat_memw    (stat_memw)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one popped expectation against the live DUT outputs.
  task automatic checkOutput(input exp_t e);
    logic [5:0] act;
    act = {freeze_pc, freeze_ifid, flush_ifid, bubble_idexe, freeze_back, mem_timeout};
    total++;
    if (act !== e.value) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", e.name, act, e.value);
    end
  endtask

  // Monitor: the outputs are valid every cycle, so one expectation is
  // consumed per falling edge whenever the queue holds one.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  // Drives one cycle of inputs just after the rising edge and queues the
  // expected combinational response for that cycle.
  task automatic applyStimulus(input string name, input logic r, input logic hz,
                               input logic br, input logic mr, input logic rdy,
                               input logic [5:0] expv);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    hazard       = hz;
    branch_taken = br;
    mem_req      = mr;
    sram_ready   = rdy;
    e.name  = name;
    e.value = expv;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; sram_ready = 1'b0;

    // Reset: outputs low even with requests present
    applyStimulus("reset_hold", 1, 1, 0, 1, 0, IDLE);
    applyStimulus("reset_br",   1, 0, 1, 0, 0, IDLE);

    // Hazard stall for two cycles
    applyStimulus("haz_1",    0, 1, 0, 0, 0, HAZ);
    applyStimulus("haz_2",    0, 1, 0, 0, 0, HAZ);
    applyStimulus("haz_idle", 0, 0, 0, 0, 0, IDLE);

    // Taken branch with three flush cycles; hazard ignored while flushing
    applyStimulus("br_1",     0, 0, 1, 0, 0, BR);
    applyStimulus("br_2",     0, 1, 0, 0, 0, FL);
    applyStimulus("br_3",     0, 1, 0, 0, 0, FL);
    applyStimulus("br_done",  0, 0, 0, 0, 0, IDLE);

    // Memory wait: four frozen cycles then release
    applyStimulus("memw_1",   0, 0, 0, 1, 0, FRZ);
    applyStimulus("memw_2",   0, 1, 1, 1, 0, FRZ);
    applyStimulus("memw_3",   0, 0, 0, 1, 0, FRZ);
    applyStimulus("memw_4",   0, 0, 0, 1, 0, FRZ);
    applyStimulus("memw_rdy", 0, 0, 0, 1, 1, IDLE);
    applyStimulus("memw_aft", 0, 0, 0, 0, 0, IDLE);
`ifdef STALL_STATS_EN
    total++;
    if (stat_memw !== 16'd4) begin
      bad++;
      $display("[TB] FAIL stat_memw: got %0d expected 4", stat_memw);
    end
`endif

    // Access completing immediately does not block a hazard
    applyStimulus("ready_haz", 0, 1, 0, 1, 1, HAZ);
    applyStimulus("ready_idl", 0, 0, 0, 0, 0, IDLE);

    // Branch together with memory wait: freeze first, flush after release
    applyStimulus("bm_frz1",  0, 0, 1, 1, 0, FRZ);
    applyStimulus("bm_frz2",  0, 0, 1, 1, 0, FRZ);
    applyStimulus("bm_rdy",   0, 0, 1, 1, 1, IDLE);
    applyStimulus("bm_br",    0, 0, 1, 0, 0, BR);
    applyStimulus("bm_fl2",   0, 0, 0, 0, 0, FL);
    applyStimulus("bm_fl3",   0, 0, 0, 0, 0, FL);
    applyStimulus("bm_done",  0, 0, 0, 0, 0, IDLE);

    // Memory wait inside a flush: flush resumes with its remaining count
    applyStimulus("fm_br",    0, 0, 1, 0, 0, BR);
    applyStimulus("fm_frz1",  0, 0, 0, 1, 0, FRZ);
    applyStimulus("fm_frz2",  0, 0, 0, 1, 0, FRZ);
    applyStimulus("fm_rdy",   0, 0, 0, 1, 1, IDLE);
    applyStimulus("fm_fl2",   0, 0, 0, 0, 0, FL);
    applyStimulus("fm_fl3",   0, 0, 0, 0, 0, FL);
    applyStimulus("fm_done",  0, 0, 0, 0, 0, IDLE);

    // Timeout: eight frozen cycles, freezes drop at count 8, flag sticks
    for (int i = 0; i < 8; i++) begin
      applyStimulus("tmo_frz", 0, 0, 0, 1, 0, FRZ);
    end
    applyStimulus("tmo_drop",  0, 0, 0, 1, 0, IDLE);
    applyStimulus("tmo_flag",  0, 0, 0, 0, 0, TMO);
    applyStimulus("tmo_stick", 0, 0, 0, 0, 0, TMO);
    applyStimulus("tmo_haz",   0, 1, 0, 0, 0, HAZ | TMO);

    // Reset in the middle of a memory wait
    applyStimulus("rw_frz1",  0, 0, 0, 1, 0, FRZ | TMO);
    applyStimulus("rw_frz2",  0, 0, 0, 1, 0, FRZ | TMO);
    applyStimulus("rw_rst",   1, 0, 0, 1, 0, IDLE);
    applyStimulus("rw_after", 0, 0, 0, 0, 0, IDLE);
    applyStimulus("rw_run",   0, 1, 0, 0, 0, HAZ);
    applyStimulus("rw_idle",  0, 0, 0, 0, 0, IDLE);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
